// File: rtl/jfive_wb_ctl_pkg.sv
// Shared constants and types for the jfive Wishbone control block.
// Optional feature macro: JFIVE_WB_CTL_CYCLE_COUNTER_EN (64-bit cycle counter at index 2).
package jfive_wb_ctl_pkg;

    // Register indices relative to the control base (address 0)
    localparam logic [3:0] REG_ID         = 4'd0;
    localparam logic [3:0] REG_STATUS     = 4'd1;
    localparam logic [3:0] REG_CYCLE      = 4'd2;
    localparam logic [3:0] REG_CORE_RESET = 4'd8;
    localparam logic [3:0] REG_CLEAR      = 4'd9;
    // Index reported for any register address outside the decoded 16-entry page
    localparam logic [3:0] REG_UNMAPPED   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Read data returned when the memory port fails to respond in time
    localparam logic [63:0] TIMEOUT_DATA = 64'hDEAD_BEEF;

endpackage

// File: rtl/jfive_wb_ctl_decode.sv
// Combinational address classifier: register page vs. instruction-memory window.
// Optional feature macro: JFIVE_WB_CTL_CYCLE_COUNTER_EN (not used here).
module jfive_wb_ctl_decode
    import jfive_wb_ctl_pkg::*;
#(
    parameter int WB_ADR_WIDTH  = 37,
    parameter int MEM_ADR_WIDTH = 14,
    parameter int MEM_BASE      = 'h8000
) (
    input  logic [WB_ADR_WIDTH-1:0]  i_adr,
    output logic                     o_is_reg,
    output logic                     o_is_mem,
    output logic [3:0]               o_reg_index,
    output logic [MEM_ADR_WIDTH-1:0] o_mem_addr
);

    // One extra bit so the window end cannot wrap for any MEM_BASE
    localparam logic [WB_ADR_WIDTH:0] WIN_LO = (WB_ADR_WIDTH+1)'(MEM_BASE);
    localparam logic [WB_ADR_WIDTH:0] WIN_HI = WIN_LO + ((WB_ADR_WIDTH+1)'(1) << MEM_ADR_WIDTH);
    localparam logic [MEM_ADR_WIDTH-1:0] BASE_LO = MEM_ADR_WIDTH'(MEM_BASE);

    logic [WB_ADR_WIDTH:0] w_adr_ext;
    logic                  w_in_page;

    // Classify the address; anything not in the window is a register access
    always_comb begin
        w_adr_ext   = {1'b0, i_adr};
        o_is_mem    = (w_adr_ext >= WIN_LO) && (w_adr_ext < WIN_HI);
        o_is_reg    = !o_is_mem;
        w_in_page   = (i_adr < WB_ADR_WIDTH'(16));
        o_reg_index = w_in_page ? i_adr[3:0] : REG_UNMAPPED;
        // Low bits of the difference depend only on low bits of the operands
        o_mem_addr  = i_adr[MEM_ADR_WIDTH-1:0] - BASE_LO;
    end

endmodule

// File: rtl/jfive_wb_ctl.sv
// Wishbone slave owning the jfive core-reset/ID/status registers and bridging
// the instruction-memory window onto a valid/ready memory port.
// Optional feature macro: JFIVE_WB_CTL_CYCLE_COUNTER_EN (64-bit cycle counter at index 2).
//
// Memory port handshake: m_mem_valid rises with addr/we/wdata/strb and all of
// them stay stable until the cycle m_mem_ready is high (transfer accepted), or
// until the timeout drops valid (transfer abandoned). Read data is taken in the
// first later cycle with m_mem_rvalid high.
module jfive_wb_ctl
    import jfive_wb_ctl_pkg::*;
#(
    parameter int          WB_ADR_WIDTH    = 37,
    parameter int          WB_DAT_WIDTH    = 64,
    parameter int          WB_SEL_WIDTH    = WB_DAT_WIDTH/8,
    parameter int          MEM_ADR_WIDTH   = 14,
    parameter int          MEM_BASE        = 'h8000,
    parameter logic [31:0] CORE_ID         = 32'h527a_0000,
    parameter logic        INIT_CORE_RESET = 1'b1,
    parameter int          TIMEOUT         = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_we_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o,
    output logic                     core_reset,
    output logic [MEM_ADR_WIDTH-1:0] m_mem_addr,
    output logic                     m_mem_we,
    output logic [31:0]              m_mem_wdata,
    output logic [3:0]               m_mem_strb,
    output logic                     m_mem_valid,
    input  logic                     m_mem_ready,
    input  logic                     m_mem_rvalid,
    input  logic [31:0]              m_mem_rdata,
    output logic [1:0]               o_dbg_state
);

    localparam int            CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    state_t                     r_state;
    logic                       r_ack;
    logic [WB_DAT_WIDTH-1:0]    r_dat;
    logic                       r_valid;
    logic                       r_core_reset;
    logic                       r_tflag;
    logic [CW-1:0]              r_cnt;
    logic [MEM_ADR_WIDTH-1:0]   r_addr;
    logic                       r_we;
    logic [31:0]                r_wdata;
    logic [3:0]                 r_strb;

    logic                       w_is_reg;
    logic                       w_is_mem;
    logic [3:0]                 w_reg_index;
    logic [MEM_ADR_WIDTH-1:0]   w_mem_addr;
    logic                       w_accept;
    logic [WB_DAT_WIDTH-1:0]    w_reg_rdata;
    logic                       w_unused_ok;

    jfive_wb_ctl_decode #(
        .WB_ADR_WIDTH  (WB_ADR_WIDTH),
        .MEM_ADR_WIDTH (MEM_ADR_WIDTH),
        .MEM_BASE      (MEM_BASE)
    ) u_decode (
        .i_adr       (s_wb_adr_i),
        .o_is_reg    (w_is_reg),
        .o_is_mem    (w_is_mem),
        .o_reg_index (w_reg_index),
        .o_mem_addr  (w_mem_addr)
    );

    // Upper data/select bits carry nothing this block uses
    assign w_unused_ok = ^{s_wb_dat_i, s_wb_sel_i};

    // A new request is taken only in IDLE and never in the ack cycle itself
    assign w_accept = (r_state == IDLE) && s_wb_stb_i && !r_ack;

`ifdef JFIVE_WB_CTL_CYCLE_COUNTER_EN
    logic [63:0] r_cycle;
    logic        w_clr_cycle;

    assign w_clr_cycle = w_accept && w_is_reg && s_wb_we_i &&
                         (w_reg_index == REG_CLEAR) && s_wb_dat_i[0];

    // Count cycles the core runs; held at zero while the core is in reset
    always_ff @(posedge clk) begin
        if (reset || r_core_reset || w_clr_cycle) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
        end
    end
`endif

    // Register read multiplexer
    always_comb begin
        w_reg_rdata = '0;
        case (w_reg_index)
            REG_ID:     w_reg_rdata = WB_DAT_WIDTH'(CORE_ID);
            REG_STATUS: w_reg_rdata = WB_DAT_WIDTH'({r_tflag, r_core_reset});
`ifdef JFIVE_WB_CTL_CYCLE_COUNTER_EN
            REG_CYCLE:  w_reg_rdata = WB_DAT_WIDTH'(r_cycle);
`endif
            default:    w_reg_rdata = '0;
        endcase
    end

    // Transaction FSM: register access, memory request, read wait, ack pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ack        <= 1'b0;
            r_dat        <= '0;
            r_valid      <= 1'b0;
            r_core_reset <= INIT_CORE_RESET;
            r_tflag      <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_strb       <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (w_is_mem) begin
                            r_state <= REQ;
                            r_valid <= 1'b1;
                            r_addr  <= w_mem_addr;
                            r_we    <= s_wb_we_i;
                            r_wdata <= s_wb_dat_i[31:0];
                            r_strb  <= s_wb_sel_i[3:0];
                            r_dat   <= '0;
                        end else if (w_is_reg) begin
                            r_state <= ACK;
                            r_dat   <= s_wb_we_i ? '0 : w_reg_rdata;
                            if (s_wb_we_i && (w_reg_index == REG_CORE_RESET) && s_wb_sel_i[0]) begin
                                r_core_reset <= s_wb_dat_i[0];
                            end
                            if (s_wb_we_i && (w_reg_index == REG_CLEAR) && s_wb_dat_i[1]) begin
                                r_tflag <= 1'b0;
                            end
                        end
                    end
                end
                REQ: begin
                    if (m_mem_ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= r_we ? ACK : RWAIT;
                    end else if (r_cnt == TO_MAX) begin
                        // Dropping valid abandons the transfer rather than letting it land late
                        r_valid <= 1'b0;
                        r_tflag <= 1'b1;
                        r_dat   <= WB_DAT_WIDTH'(TIMEOUT_DATA);
                        r_cnt   <= '0;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RWAIT: begin
                    if (m_mem_rvalid) begin
                        r_dat   <= WB_DAT_WIDTH'(m_mem_rdata);
                        r_cnt   <= '0;
                        r_state <= ACK;
                    end else if (r_cnt == TO_MAX) begin
                        r_tflag <= 1'b1;
                        r_dat   <= WB_DAT_WIDTH'(TIMEOUT_DATA);
                        r_cnt   <= '0;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ACK: begin
                    r_ack   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_wb_ack_o  = r_ack;
    assign s_wb_dat_o  = r_dat;
    assign core_reset  = r_core_reset;
    assign m_mem_addr  = r_addr;
    assign m_mem_we    = r_we;
    assign m_mem_wdata = r_wdata;
    assign m_mem_strb  = r_strb;
    assign m_mem_valid = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jfive_wb_ctl.sv
// Self-checking bench for jfive_wb_ctl: register vector table, memory write
// burst with a stalling responder, delayed read, timeout and mid-transfer reset.
module tb_jfive_wb_ctl;

    localparam int MEM_BASE = 'h8000;
    localparam int TIMEOUT  = 255;

    logic        clk;
    logic        reset;
    logic [36:0] s_wb_adr_i;
    logic [63:0] s_wb_dat_o;
    logic [63:0] s_wb_dat_i;
    logic [7:0]  s_wb_sel_i;
    logic        s_wb_we_i;
    logic        s_wb_stb_i;
    logic        s_wb_ack_o;
    logic        core_reset;
    logic [13:0] m_mem_addr;
    logic        m_mem_we;
    logic [31:0] m_mem_wdata;
    logic [3:0]  m_mem_strb;
    logic        m_mem_valid;
    logic        m_mem_ready;
    logic        m_mem_rvalid;
    logic [31:0] m_mem_rdata;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected memory handshakes {we, addr, wdata, strb}
    logic [50:0] exp_q[$];
    int          hs_cnt = 0;

    // Responder controls
    logic        tie_ready0 = 1'b0;
    int          rd_delay   = 1;
    logic [31:0] rd_data    = 32'h0;

    jfive_wb_ctl dut (
        .clk          (clk),
        .reset        (reset),
        .s_wb_adr_i   (s_wb_adr_i),
        .s_wb_dat_o   (s_wb_dat_o),
        .s_wb_dat_i   (s_wb_dat_i),
        .s_wb_sel_i   (s_wb_sel_i),
        .s_wb_we_i    (s_wb_we_i),
        .s_wb_stb_i   (s_wb_stb_i),
        .s_wb_ack_o   (s_wb_ack_o),
        .core_reset   (core_reset),
        .m_mem_addr   (m_mem_addr),
        .m_mem_we     (m_mem_we),
        .m_mem_wdata  (m_mem_wdata),
        .m_mem_strb   (m_mem_strb),
        .m_mem_valid  (m_mem_valid),
        .m_mem_ready  (m_mem_ready),
        .m_mem_rvalid (m_mem_rvalid),
        .m_mem_rdata  (m_mem_rdata),
        .o_dbg_state  (o_dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Memory responder: drives inputs on the falling edge, checks each handshake
    initial begin : responder
        int          stall;
        int          rd_cnt;
        logic [50:0] got;
        logic [50:0] want;
        m_mem_ready  = 1'b0;
        m_mem_rvalid = 1'b0;
        m_mem_rdata  = 32'h0;
        stall        = $urandom_range(0, 3);
        rd_cnt       = -1;
        forever begin
            @(negedge clk);
            m_mem_ready  = 1'b0;
            m_mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    m_mem_rvalid = 1'b1;
                    m_mem_rdata  = rd_data;
                    rd_cnt       = -1;
                end
            end else if (m_mem_valid && !tie_ready0 && !reset) begin
                if (stall == 0) begin
                    m_mem_ready = 1'b1;
                    hs_cnt++;
                    got = {m_mem_we, m_mem_addr, m_mem_wdata, m_mem_strb};
                    if (exp_q.size() == 0) begin
                        check("hs_unexpected", 64'(got), 64'h0);
                    end else begin
                        want = exp_q.pop_front();
                        check("hs_fields", 64'(got), 64'(want));
                    end
                    if (!m_mem_we) rd_cnt = rd_delay;
                    stall = $urandom_range(0, 3);
                end else begin
                    stall--;
                end
            end
        end
    end

    // One Wishbone access; returns read data, cycles from stb sample to ack, and
    // whether ack was gone again one cycle later
    task automatic wb_xfer(input logic [36:0] adr, input logic we, input logic [63:0] dat,
                           input logic [7:0] sel, output logic [63:0] rd, output int cyc,
                           output logic pulse_ok);
        @(negedge clk);
        s_wb_adr_i = adr;
        s_wb_we_i  = we;
        s_wb_dat_i = dat;
        s_wb_sel_i = sel;
        s_wb_stb_i = 1'b1;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_wb_ack_o || cyc > 1000) break;
        end
        rd = s_wb_dat_o;
        @(negedge clk);
        s_wb_stb_i = 1'b0;
        s_wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
        pulse_ok = !s_wb_ack_o;
    endtask

    typedef struct {
        logic        we;
        logic [36:0] adr;
        logic [63:0] dat;
        logic [7:0]  sel;
        logic        chk_dat;
        logic [63:0] exp_dat;
        logic        exp_cr;
    } vec_t;

    vec_t vecs[12];
    int   n_vec;

    initial begin : main
        logic [63:0] rd;
        int          cyc;
        logic        pok;

        // Register vectors, hand-computed
        n_vec = 0;
        vecs[n_vec++] = '{1'b0, 37'd0,               64'd0,     8'hff, 1'b1, 64'h527a_0000, 1'b1};
        vecs[n_vec++] = '{1'b0, 37'd1,               64'd0,     8'hff, 1'b1, 64'h1,         1'b1};
        vecs[n_vec++] = '{1'b0, 37'd3,               64'd0,     8'hff, 1'b1, 64'h0,         1'b1};
`ifndef JFIVE_WB_CTL_CYCLE_COUNTER_EN
        vecs[n_vec++] = '{1'b0, 37'd2,               64'd0,     8'hff, 1'b1, 64'h0,         1'b1};
`endif
        vecs[n_vec++] = '{1'b1, 37'd8,               64'd0,     8'hfe, 1'b0, 64'h0,         1'b1};
        vecs[n_vec++] = '{1'b0, 37'd1,               64'd0,     8'hff, 1'b1, 64'h1,         1'b1};
        vecs[n_vec++] = '{1'b1, 37'd8,               64'd0,     8'hff, 1'b0, 64'h0,         1'b0};
        vecs[n_vec++] = '{1'b0, 37'd1,               64'd0,     8'hff, 1'b1, 64'h0,         1'b0};
        vecs[n_vec++] = '{1'b1, 37'(MEM_BASE+16384), 64'hffff,  8'hff, 1'b0, 64'h0,         1'b0};
        vecs[n_vec++] = '{1'b0, 37'(MEM_BASE+16384), 64'd0,     8'hff, 1'b1, 64'h0,         1'b0};
        vecs[n_vec++] = '{1'b0, 37'(MEM_BASE-1),     64'd0,     8'hff, 1'b1, 64'h0,         1'b0};

        // Clock/reset
        reset      = 1'b1;
        s_wb_adr_i = '0;
        s_wb_dat_i = '0;
        s_wb_sel_i = '0;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   64'(s_wb_ack_o),  64'h0);
        check("rst_dat",   s_wb_dat_o,       64'h0);
        check("rst_valid", 64'(m_mem_valid), 64'h0);
        check("rst_cr",    64'(core_reset),  64'h1);
        check("rst_state", 64'(o_dbg_state), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Register table
        for (int i = 0; i < n_vec; i++) begin
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd, cyc, pok);
            if (vecs[i].chk_dat) check($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
            check($sformatf("vec%0d_lat", i),   64'(cyc),        64'd2);
            check($sformatf("vec%0d_pulse", i), 64'(pok),        64'h1);
            check($sformatf("vec%0d_cr", i),    64'(core_reset), 64'(vecs[i].exp_cr));
        end

        // Memory write burst with random ready stalls
        for (int i = 0; i < 2048; i++) begin
            exp_q.push_back({1'b1, 14'(i), 32'(i*3), 4'hf});
            wb_xfer(37'(MEM_BASE+i), 1'b1, 64'(i*3), 8'hff, rd, cyc, pok);
        end
        check("burst_hs_count", 64'(hs_cnt),       64'd2048);
        check("burst_q_empty",  64'(exp_q.size()), 64'd0);

        // Memory read, rvalid 4 cycles after ready
        rd_delay = 4;
        rd_data  = 32'h1234_5678;
        exp_q.push_back({1'b0, 14'd5, 32'h0, 4'hf});
        wb_xfer(37'(MEM_BASE+5), 1'b0, 64'h0, 8'hff, rd, cyc, pok);
        check("rd_dat",   rd,       64'h0000_0000_1234_5678);
        check("rd_pulse", 64'(pok), 64'h1);
        check("rd_q_empty", 64'(exp_q.size()), 64'd0);

        // Timeout on a read that is never accepted
        tie_ready0 = 1'b1;
        wb_xfer(37'(MEM_BASE), 1'b0, 64'h0, 8'hff, rd, cyc, pok);
        check("to_dat", rd, 64'hDEAD_BEEF);
        check("to_lat_window", 64'((cyc >= TIMEOUT) && (cyc <= TIMEOUT + 4)), 64'h1);
        tie_ready0 = 1'b0;
        wb_xfer(37'd1, 1'b0, 64'h0, 8'hff, rd, cyc, pok);
        check("to_status_set", rd, 64'h2);
        wb_xfer(37'd9, 1'b1, 64'h2, 8'hff, rd, cyc, pok);
        wb_xfer(37'd1, 1'b0, 64'h0, 8'hff, rd, cyc, pok);
        check("to_status_clr", rd, 64'h0);

        // Reset while the request is pending
        tie_ready0 = 1'b1;
        @(negedge clk);
        s_wb_adr_i = 37'(MEM_BASE+7);
        s_wb_we_i  = 1'b0;
        s_wb_sel_i = 8'hff;
        s_wb_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_valid", 64'(m_mem_valid), 64'h1);
        check("mid_state", 64'(o_dbg_state), 64'h1);
        @(negedge clk);
        reset      = 1'b1;
        s_wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", 64'(m_mem_valid), 64'h0);
        check("mid_rst_cr",    64'(core_reset),  64'h1);
        @(negedge clk);
        reset      = 1'b0;
        tie_ready0 = 1'b0;
        wb_xfer(37'd0, 1'b0, 64'h0, 8'hff, rd, cyc, pok);
        check("post_rst_id",  rd,       64'h527a_0000);
        check("post_rst_lat", 64'(cyc), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
